shift_code_monitor: RTL
=======================

// Module: shift_code_monitor
// PURPOSE
//  Receive-side checker for the ring and Johnson shift-register counters.
//  - Samples an N-bit ring or Johnson code.
//  - Decodes it to a binary index and flags illegal codes.
//  - Checks each sample is the successor of the previous one.
//  - Runs a lock FSM and keeps a saturating error counter.
//  Sits beside a counter instance as a health monitor or a code-to-index decoder.
// PARAMETERS
//  N        4  code width (>=2); must match the monitored counter
//  LOCK_CNT 4  consecutive good transitions required to reach LOCKED (>=1)
//  ERR_W    8  error counter width
//  IDX_W    $clog2(2*N)  derived localparam; index width
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  mode         in   1      0 = ring code, 1 = Johnson code
//  sample_valid in   1      code is sampled on this cycle
//  code         in   N      counter value under test
//  clr_err      in   1      synchronous clear of err_cnt
//  idx          out  IDX_W  decoded index of the last legal sample
//  idx_valid    out  1      1-cycle pulse: idx updated
//  illegal      out  1      1-cycle pulse: last sample was not a legal code
//  seq_err      out  1      1-cycle pulse: error detected while LOCKED
//  locked       out  1      FSM is in LOCKED
//  err_cnt      out  ERR_W  saturating count of seq_err events
// BEHAVIOUR
//  Reset values: state=HUNT, run=0, prev=0, and every output is 0.
//  Latency: all outputs are registered, updating on the edge where
//   sample_valid=1 is seen. With no sample_valid, pulses are 0 and the rest hold.
//  Ring decode (M=N states):
//   - legal iff exactly one bit is set; idx = position of that bit.
//   - 0..01 is idx 0.
//  Johnson decode (M=2N states):
//   - k ones packed at the LSB end (k=0..N) -> idx k.
//   - N-j ones packed at the MSB end, j=1..N-1 -> idx N+j.
//   - For N=4: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7.
//   - Every other pattern is illegal.
//  Successor rule: legal sample with idx == (prev+1) mod M. This includes wrap M-1 -> 0.
//   A repeated identical code is a mismatch.
//  FSM, evaluated only on sample_valid:
//   HUNT:
//    - legal -> ACQ, prev=idx, run=0.
//    - illegal -> stay in HUNT.
//   ACQ:
//    - successor -> run++; when run reaches LOCK_CNT -> LOCKED.
//    - legal non-successor -> stay in ACQ, run=0, prev=idx.
//    - illegal -> HUNT.
//   LOCKED:
//    - successor -> stay.
//    - legal non-successor -> seq_err, then ACQ, run=0, prev=idx.
//    - illegal -> seq_err, then HUNT.
//  Pulses and idx:
//   - illegal pulses for any illegal sample, in any state.
//   - idx and idx_valid update only on legal samples.
//   - On an illegal sample idx holds its last value.
//  Mode change: any change in mode vs. the previous cycle forces HUNT and run=0
//   on that edge. It overrides sample processing and produces no seq_err.
//  err_cnt:
//   - increments on each seq_err and saturates at all-ones.
//   - clr_err wins over a simultaneous increment: result is 0.
//  Reset asserted mid-operation clears everything asynchronously. Monitoring
//   restarts in HUNT on the first sample_valid after release.
// TESTING  (N=4, LOCK_CNT=4 unless stated)
//  1 Johnson mode, samples 0000,0001,0011,0111,1111 -> idx 0..4 with idx_valid
//    each time; locked=1 after the 5th sample. Continuing 1110,1100,1000,0000
//    (wrap 7->0) keeps locked=1.
//  2 Ring mode, 0001,0010,0100,1000,0001 -> idx 0,1,2,3,0; locked=1 after the
//    wrap sample; illegal=0 throughout.
//  3 Johnson LOCKED at idx 3, inject 0101 -> illegal=1, seq_err=1, err_cnt=1,
//    locked=0, idx holds 3. Next 0111 -> ACQ; locked again after 4 more successors.
//  4 Johnson LOCKED at idx 2 (0011), then 1111 (skip to 4) -> seq_err=1,
//    illegal=0, idx=4, locked=0. 1110,1100,1000,0000 -> locked=1.
//  5 ERR_W=2: force 5 LOCKED errors -> err_cnt saturates at 3. clr_err
//    coincident with a seq_err -> err_cnt=0.
//  6 While LOCKED, toggle mode -> locked=0 and no seq_err. Separately, pulse
//    rst_n low mid-sequence -> all outputs 0 immediately; relock needs 5 samples.

Source files
------------

// File: rtl/shift_code_if.sv
// Sample/result bundle between a shift-code source and the shift_code_monitor.
// The master drives the sampled code and control; the slave returns decode and health status.
interface shift_code_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    localparam int IDX_W = $clog2(2 * N);

    logic             mode;
    logic             sample_valid;
    logic [N-1:0]     code;
    logic             clr_err;
    logic [IDX_W-1:0] idx;
    logic             idx_valid;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output mode, sample_valid, code, clr_err,
        input  idx, idx_valid, illegal, seq_err, locked, err_cnt
    );

    modport slave (
        input  mode, sample_valid, code, clr_err,
        output idx, idx_valid, illegal, seq_err, locked, err_cnt
    );
endinterface

// File: rtl/shift_code_monitor.sv
// Health monitor for ring/Johnson shift counters: decodes each sample to an index,
// flags illegal codes, checks successor order, tracks lock and counts sequence errors.
module shift_code_monitor #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    shift_code_if.slave mon
);
    localparam int IDX_W = $clog2(2 * N);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [IDX_W-1:0] prev_q, prev_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             illegal_q, illegal_d;
    logic             seq_err_q, seq_err_d;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    // Returns {legal, index}; legal only when exactly one bit is set.
    function automatic logic [IDX_W:0] decode_ring(input logic [N-1:0] c);
        int               cnt;
        logic [IDX_W-1:0] pos;
        cnt = 0;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            if (c[i]) begin
                cnt++;
                pos = IDX_W'(i);
            end
        end
        return {(cnt == 1), pos};
    endfunction

    // Returns {legal, index}; k low ones -> k, N-k high ones -> N+k.
    function automatic logic [IDX_W:0] decode_johnson(input logic [N-1:0] c);
        logic [N:0]       one_hot;
        logic [N-1:0]     lo_mask;
        logic             hit;
        logic [IDX_W-1:0] pos;
        hit = 1'b0;
        pos = '0;
        for (int k = 0; k <= N; k++) begin
            one_hot    = '0;
            one_hot[k] = 1'b1;
            lo_mask    = N'(one_hot - (N + 1)'(1));
            if (c == lo_mask) begin
                hit = 1'b1;
                pos = IDX_W'(k);
            end
            if (k >= 1 && k <= N - 1 && c == ~lo_mask) begin
                hit = 1'b1;
                pos = IDX_W'(N + k);
            end
        end
        return {hit, pos};
    endfunction

    logic [IDX_W:0]   dec;
    logic             legal;
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] succ_idx;
    logic             is_succ;
    logic [RUN_W-1:0] run_inc;
    logic             seq_err_evt;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        prev_d      = prev_q;
        mode_d      = mon.mode;
        idx_d       = idx_q;
        idx_valid_d = 1'b0;
        illegal_d   = 1'b0;
        seq_err_evt = 1'b0;
        err_cnt_d   = err_cnt_q;

        dec      = mon.mode ? decode_johnson(mon.code) : decode_ring(mon.code);
        legal    = dec[IDX_W];
        dec_idx  = dec[IDX_W-1:0];
        last_idx = mon.mode ? IDX_W'(2 * N - 1) : IDX_W'(N - 1);
        succ_idx = (prev_q == last_idx) ? '0 : prev_q + IDX_W'(1);
        is_succ  = legal && (dec_idx == succ_idx);
        run_inc  = run_q + RUN_W'(1);

        // A mode switch invalidates the history, so the sample on that edge is discarded.
        if (mon.mode != mode_q) begin
            state_d = HUNT;
            run_d   = '0;
        end else if (mon.sample_valid) begin
            illegal_d = !legal;
            if (legal) begin
                idx_d       = dec_idx;
                idx_valid_d = 1'b1;
            end
            unique case (state_q)
                HUNT: begin
                    if (legal) begin
                        state_d = ACQ;
                        prev_d  = dec_idx;
                        run_d   = '0;
                    end
                end
                ACQ: begin
                    if (!legal) begin
                        state_d = HUNT;
                        run_d   = '0;
                    end else if (is_succ) begin
                        prev_d = dec_idx;
                        run_d  = run_inc;
                        if (run_inc == RUN_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        prev_d = dec_idx;
                        run_d  = '0;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        seq_err_evt = 1'b1;
                        state_d     = HUNT;
                        run_d       = '0;
                    end else if (!is_succ) begin
                        seq_err_evt = 1'b1;
                        state_d     = ACQ;
                        prev_d      = dec_idx;
                        run_d       = '0;
                    end else begin
                        prev_d = dec_idx;
                    end
                end
                default: begin
                    state_d = HUNT;
                    run_d   = '0;
                end
            endcase
        end

        seq_err_d = seq_err_evt;
        locked_d  = (state_d == LOCKED);

        if (mon.clr_err) begin
            err_cnt_d = '0;
        end else if (seq_err_evt && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            run_q       <= '0;
            prev_q      <= '0;
            mode_q      <= 1'b0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            illegal_q   <= illegal_d;
            seq_err_q   <= seq_err_d;
            locked_q    <= locked_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign mon.idx       = idx_q;
    assign mon.idx_valid = idx_valid_q;
    assign mon.illegal   = illegal_q;
    assign mon.seq_err   = seq_err_q;
    assign mon.locked    = locked_q;
    assign mon.err_cnt   = err_cnt_q;
endmodule
